// File: rtl/sync_fifo_prog_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog_if
//
// Bundles the write side, read side and status signals of sync_fifo_prog.
//   master : the producer/consumer side (drives wr_en, din, rd_en)
//   slave  : the FIFO itself (drives data, flags, count, error strobes)
//
// Signals
//   wr_en, din                write request and data
//   rd_en                     read request / FWFT head acknowledge
//   dout, valid               read data and its qualifier
//   full, empty               occupancy at DEPTH / at zero
//   prog_full, prog_empty     programmable threshold flags
//   data_count                occupancy 0..DEPTH
//   overflow, underflow       rejected write / rejected read indications
// -----------------------------------------------------------------------------
interface sync_fifo_prog_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;
  logic             prog_full;
  logic             empty;
  logic             prog_empty;
  logic [CW-1:0]    data_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, valid, full, prog_full, empty, prog_empty,
           data_count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, valid, full, prog_full, empty, prog_empty,
           data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//
// Single-clock FIFO with selectable read mode, programmable full/empty
// thresholds, an occupancy count and overflow/underflow reporting. Storage is
// a plain inferred array.
//
// Parameters
//   WIDTH              data width (>= 1)
//   DEPTH              entries, power of two, >= 4
//   PROG_FULL_THRESH   prog_full when count >= this (1..DEPTH)
//   PROG_EMPTY_THRESH  prog_empty when count <= this (0..DEPTH-1)
//   FWFT               1: head word presented on dout while not empty
//                      0: dout registered, loaded on an accepted read
//
// Ports
//   clk   system clock
//   rst   synchronous, active-high reset (pointers, count, flags, dout,
//         valid and error outputs; storage contents are kept)
//   bus   sync_fifo_prog_if.slave, see the interface for the signal list
//
// Build option
//   SYNC_FIFO_STICKY_ERR_EN  when defined, overflow/underflow hold high once
//                            set until rst; otherwise they pulse for one
//                            cycle per rejected request.
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int WIDTH             = 8,
  parameter int DEPTH             = 16,
  parameter int PROG_FULL_THRESH  = 14,
  parameter int PROG_EMPTY_THRESH = 2,
  parameter int FWFT              = 1
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_prog_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] PF_LVL   = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_LVL   = CW'(PROG_EMPTY_THRESH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic empty_q;
  logic full_q;
  logic prog_full_q;
  logic prog_empty_q;
  logic overflow_q;
  logic underflow_q;

  logic rd_acc;
  logic wr_acc;
  logic overflow_evt;
  logic underflow_evt;
  logic overflow_nxt;
  logic underflow_nxt;

  logic [WIDTH-1:0] dout_w;
  logic             valid_w;

  // ---------------------------------------------------------------------------
  // Acceptance
  // ---------------------------------------------------------------------------
  // A read is only possible when something is stored. A write into a full
  // FIFO is allowed when a read frees a slot in the same cycle; a write into
  // an empty FIFO never lets a same-cycle read through (the word is not yet
  // at the head), so that read is rejected.
  assign rd_acc = bus.rd_en & ~empty_q;
  assign wr_acc = bus.wr_en & (~full_q | rd_acc);

  assign overflow_evt  = bus.wr_en & ~wr_acc;
  assign underflow_evt = bus.rd_en & empty_q;

`ifdef SYNC_FIFO_STICKY_ERR_EN
  assign overflow_nxt  = overflow_q  | overflow_evt;
  assign underflow_nxt = underflow_q | underflow_evt;
`else
  assign overflow_nxt  = overflow_evt;
  assign underflow_nxt = underflow_evt;
`endif

  // ---------------------------------------------------------------------------
  // Next occupancy
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers, count and flags
  // ---------------------------------------------------------------------------
  // Flags are registered from count_nxt rather than decoded from count, so
  // they are launched straight from flops and stay in step with data_count.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt;
      empty_q      <= (count_nxt == '0);
      full_q       <= (count_nxt == FULL_LVL);
      prog_full_q  <= (count_nxt >= PF_LVL);
      prog_empty_q <= (count_nxt <= PE_LVL);
      overflow_q   <= overflow_nxt;
      underflow_q  <= underflow_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately not reset; a reset port on it would stop
  // RAM inference, and stale contents are never visible because the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= bus.din;
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  if (FWFT != 0) begin : g_fwft
    // Head word is shown as soon as it is stored; rd_en only pops it.
    always_comb begin
      dout_w  = '0;
      valid_w = ~empty_q;
      if (!empty_q) dout_w = mem[rd_ptr];
    end
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // dout keeps the last word read; valid marks the cycle it was loaded.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign dout_w  = dout_q;
    assign valid_w = valid_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.dout       = dout_w;
  assign bus.valid      = valid_w;
  assign bus.full       = full_q;
  assign bus.prog_full  = prog_full_q;
  assign bus.empty      = empty_q;
  assign bus.prog_empty = prog_empty_q;
  assign bus.data_count = count;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
//
// Directed bench for sync_fifo_prog. One instance runs in first-word-fall-
// through mode (u_fwft) and one in standard mode (u_std), both with DEPTH=16,
// PROG_FULL_THRESH=14, PROG_EMPTY_THRESH=2. Inputs change and outputs are
// sampled 1 ns after the rising edge. Error-flag expectations follow
// SYNC_FIFO_STICKY_ERR_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_fifo_prog;

`ifdef SYNC_FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  sync_fifo_prog_if #(.WIDTH(8), .DEPTH(16)) a_if ();
  sync_fifo_prog_if #(.WIDTH(8), .DEPTH(16)) b_if ();

  sync_fifo_prog #(
    .WIDTH(8), .DEPTH(16), .PROG_FULL_THRESH(14), .PROG_EMPTY_THRESH(2), .FWFT(1)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  sync_fifo_prog #(
    .WIDTH(8), .DEPTH(16), .PROG_FULL_THRESH(14), .PROG_EMPTY_THRESH(2), .FWFT(0)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " a count"},     32'(a_if.data_count), 0);
    check({tag, " a empty"},     32'(a_if.empty),      1);
    check({tag, " a pempty"},    32'(a_if.prog_empty), 1);
    check({tag, " a full"},      32'(a_if.full),       0);
    check({tag, " a pfull"},     32'(a_if.prog_full),  0);
    check({tag, " a dout"},      32'(a_if.dout),       0);
    check({tag, " a valid"},     32'(a_if.valid),      0);
    check({tag, " a overflow"},  32'(a_if.overflow),   0);
    check({tag, " a underflow"}, 32'(a_if.underflow),  0);
  endtask

  task automatic check_reset_b(input string tag);
    check({tag, " b count"},     32'(b_if.data_count), 0);
    check({tag, " b empty"},     32'(b_if.empty),      1);
    check({tag, " b pempty"},    32'(b_if.prog_empty), 1);
    check({tag, " b full"},      32'(b_if.full),       0);
    check({tag, " b dout"},      32'(b_if.dout),       0);
    check({tag, " b valid"},     32'(b_if.valid),      0);
    check({tag, " b overflow"},  32'(b_if.overflow),   0);
    check({tag, " b underflow"}, 32'(b_if.underflow),  0);
  endtask

  initial begin
    rst = 1'b1;
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.din = '0;
    b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.din = '0;

    // ---- reset; requests during reset must be ignored ----
    tick();
    a_if.wr_en = 1'b1; a_if.din = 8'hEE; a_if.rd_en = 1'b1;
    tick();
    check_reset_a("por");
    check_reset_b("por");
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
    rst = 1'b0;

    // ---- FWFT single word 0xA5 ----
    a_if.wr_en = 1'b1; a_if.din = 8'hA5;
    tick();
    a_if.wr_en = 1'b0;
    check("fwft a5 dout",  32'(a_if.dout),       32'hA5);
    check("fwft a5 valid", 32'(a_if.valid),      1);
    check("fwft a5 count", 32'(a_if.data_count), 1);
    check("fwft a5 empty", 32'(a_if.empty),      0);
    a_if.rd_en = 1'b1;
    tick();
    a_if.rd_en = 1'b0;
    check("fwft pop empty", 32'(a_if.empty),      1);
    check("fwft pop valid", 32'(a_if.valid),      0);
    check("fwft pop dout",  32'(a_if.dout),       0);
    check("fwft pop count", 32'(a_if.data_count), 0);
    check("fwft pop uflow", 32'(a_if.underflow),  0);

    // ---- fill with 0x01..0x10, no reads ----
    for (int i = 1; i <= 16; i++) begin
      a_if.wr_en = 1'b1; a_if.din = 8'(i);
      tick();
      check($sformatf("fill%0d count", i),  32'(a_if.data_count), 32'(i));
      check($sformatf("fill%0d pfull", i),  32'(a_if.prog_full),  32'(i >= 14));
      check($sformatf("fill%0d pempty", i), 32'(a_if.prog_empty), 32'(i <= 2));
      check($sformatf("fill%0d full", i),   32'(a_if.full),       32'(i == 16));
      check($sformatf("fill%0d head", i),   32'(a_if.dout),       32'h01);
    end

    // ---- 17th write is rejected ----
    a_if.din = 8'h11;
    tick();
    a_if.wr_en = 1'b0;
    check("ovf raised", 32'(a_if.overflow),   1);
    check("ovf count",  32'(a_if.data_count), 16);
    check("ovf full",   32'(a_if.full),       1);
    tick();
    check("ovf after",  32'(a_if.overflow),   32'(STICKY));
    check("ovf head",   32'(a_if.dout),       32'h01);

    // ---- full FIFO, simultaneous write and read for 40 cycles ----
    for (int i = 0; i < 40; i++) begin
      a_if.wr_en = 1'b1; a_if.rd_en = 1'b1; a_if.din = 8'(32'h20 + i);
      check($sformatf("thru%0d head", i), 32'(a_if.dout),
            (i < 16) ? 32'(i + 1) : 32'(32'h20 + i - 16));
      tick();
      check($sformatf("thru%0d count", i), 32'(a_if.data_count), 16);
      check($sformatf("thru%0d ovf", i),   32'(a_if.overflow),   32'(STICKY));
    end
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
    check("thru end full", 32'(a_if.full), 1);
    check("thru end head", 32'(a_if.dout), 32'h38);

    // ---- drain to 9 and reset mid-stream ----
    a_if.rd_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    a_if.rd_en = 1'b0;
    check("drain count", 32'(a_if.data_count), 9);
    check("drain head",  32'(a_if.dout),       32'h3F);
    check("drain pfull", 32'(a_if.prog_full),  0);
    rst = 1'b1;
    a_if.wr_en = 1'b1; a_if.rd_en = 1'b1; a_if.din = 8'h77;
    tick();
    check_reset_a("mid");
    rst = 1'b0;

    // ---- resume: write on empty with rd_en -> write taken, read rejected ----
    a_if.din = 8'h55;
    tick();
    a_if.rd_en = 1'b0; a_if.din = 8'h66;
    check("resume count", 32'(a_if.data_count), 1);
    check("resume dout",  32'(a_if.dout),       32'h55);
    check("resume uflow", 32'(a_if.underflow),  1);
    tick();
    a_if.wr_en = 1'b0;
    check("resume2 count", 32'(a_if.data_count), 2);
    check("resume2 uflow", 32'(a_if.underflow),  32'(STICKY));
    a_if.rd_en = 1'b1;
    tick();
    a_if.rd_en = 1'b0;
    check("resume pop dout", 32'(a_if.dout), 32'h66);

    // ---- standard mode: 0x3C, then read, then an extra read ----
    b_if.wr_en = 1'b1; b_if.din = 8'h3C;
    tick();
    b_if.wr_en = 1'b0;
    check("std wr count", 32'(b_if.data_count), 1);
    check("std wr valid", 32'(b_if.valid),      0);
    check("std wr dout",  32'(b_if.dout),       0);
    b_if.rd_en = 1'b1;
    tick();
    b_if.rd_en = 1'b0;
    check("std rd dout",  32'(b_if.dout),  32'h3C);
    check("std rd valid", 32'(b_if.valid), 1);
    check("std rd empty", 32'(b_if.empty), 1);
    tick();
    check("std pulse end", 32'(b_if.valid), 0);
    check("std hold dout", 32'(b_if.dout),  32'h3C);
    b_if.rd_en = 1'b1;
    tick();
    b_if.rd_en = 1'b0;
    check("std uflow",      32'(b_if.underflow), 1);
    check("std uflow dout", 32'(b_if.dout),      32'h3C);
    check("std uflow valid", 32'(b_if.valid),    0);
    tick();
    check("std uflow after", 32'(b_if.underflow), 32'(STICKY));

    // ---- standard mode at the full boundary ----
    b_if.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_if.din = 8'(32'h80 + i);
      tick();
    end
    check("std full", 32'(b_if.full), 1);
    b_if.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_if.din = 8'(32'h90 + i);
      tick();
      check($sformatf("std fb%0d dout", i),  32'(b_if.dout),       32'(32'h80 + i));
      check($sformatf("std fb%0d valid", i), 32'(b_if.valid),      1);
      check($sformatf("std fb%0d count", i), 32'(b_if.data_count), 16);
      check($sformatf("std fb%0d ovf", i),   32'(b_if.overflow),   0);
    end
    b_if.wr_en = 1'b0; b_if.rd_en = 1'b0;

    // ---- final reset clears everything including sticky errors ----
    rst = 1'b1;
    tick();
    check_reset_a("end");
    check_reset_b("end");
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
